// File: rtl/request_pending_scheduler_16_pkg.sv
// Shared constants and FSM state encoding for the pending-request scheduler
// and its lowest-index finder.
package request_pending_scheduler_16_pkg;
   localparam int NUM_REQ  = 16;
   localparam int ID_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;
endpackage

// File: rtl/request_pending_scheduler_16_lowest_index_find_16.sv
// Combinational finder: index of the lowest set bit (bit 0 wins) plus an any-set flag.
module lowest_index_find_16
   import request_pending_scheduler_16_pkg::*;
(
   input  logic [NUM_REQ-1:0]  vec_i,
   output logic [ID_WIDTH-1:0] index_o,
   output logic                any_o
);

   always_comb begin
      index_o = '0;
      any_o   = |vec_i;
      // Scan from the top so the lowest set bit is the last one written.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (vec_i[i]) index_o = i[ID_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/request_pending_scheduler_16.sv
// Captures request events into a pending register and offers the lowest-index
// unmasked pending request downstream; the pending bit retires on acceptance.
module request_pending_scheduler_16
   import request_pending_scheduler_16_pkg::*;
#(
   parameter int EDGE_DETECT = 1
) (
   input  logic                Clock_In,
   input  logic                Reset_N_In,
   input  logic                Enable_In,
   input  logic [NUM_REQ-1:0]  Request_In,
   input  logic [NUM_REQ-1:0]  Mask_In,
   input  logic                Clear_All_In,
   input  logic                Grant_Ready_In,
   output logic                Grant_Valid_Out,
   output logic [ID_WIDTH-1:0] Grant_Index_Out,
   output logic [NUM_REQ-1:0]  Pending_Out,
   output logic                Overflow_Out,
   input  logic                Overflow_Clear_In,
   output state_t              Dbg_State_Out
);

   // Handshake: a transfer happens on a rising edge where Grant_Valid_Out and
   // Grant_Ready_In are both high; Grant_Index_Out never changes while valid is high.

   logic [NUM_REQ-1:0]  pending_q, pending_d;
   logic [NUM_REQ-1:0]  prev_q;
   logic [ID_WIDTH-1:0] index_q, index_d;
   logic                overflow_q, overflow_d;
   state_t              state_q, state_d;

   logic [NUM_REQ-1:0]  evt;
   logic [NUM_REQ-1:0]  eligible;
   logic [NUM_REQ-1:0]  hs_mask;
   logic [ID_WIDTH-1:0] sel;
   logic                any_elig;
   logic                handshake;

   assign evt       = (EDGE_DETECT != 0) ? (Request_In & ~prev_q) : Request_In;
   assign eligible  = pending_q & ~Mask_In;
   assign handshake = (state_q == OFFER) && Grant_Ready_In;

   lowest_index_find_16 u_find (
      .vec_i   (eligible),
      .index_o (sel),
      .any_o   (any_elig)
   );

   always_comb begin
      hs_mask = '0;
      if (handshake) hs_mask[index_q] = 1'b1;
   end

   // Retiring bit is excluded from overflow so a fresh edge during acceptance just re-arms it.
   always_comb begin
      pending_d  = Clear_All_In ? '0 : ((pending_q & ~hs_mask) | evt);
      overflow_d = (|(evt & pending_q & ~hs_mask)) | (overflow_q & ~Overflow_Clear_In);
   end

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      unique case (state_q)
         IDLE: begin
            if (Enable_In && any_elig && !Clear_All_In) begin
               index_d = sel;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (Grant_Ready_In || Clear_All_In) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         pending_q  <= '0;
         prev_q     <= '0;
         index_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
      end else begin
         pending_q  <= pending_d;
         prev_q     <= Request_In;
         index_q    <= index_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
      end
   end

   assign Grant_Valid_Out = (state_q == OFFER);
   assign Grant_Index_Out = index_q;
   assign Pending_Out     = pending_q;
   assign Overflow_Out    = overflow_q;
   assign Dbg_State_Out   = state_q;

endmodule

// File: tb/tb_request_pending_scheduler_16.sv
// Self-checking bench for request_pending_scheduler_16: directed scenarios with
// inline checks plus a scoreboard that checks every accepted grant index.
module tb_request_pending_scheduler_16;
   import request_pending_scheduler_16_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] request = '0;
   logic [15:0] mask = '0;
   logic        clear_all = 1'b0;
   logic        grant_ready = 1'b0;
   logic        grant_valid;
   logic [3:0]  grant_index;
   logic [15:0] pending;
   logic        overflow;
   logic        overflow_clear = 1'b0;
   state_t      dbg_state;

   logic [3:0]  exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;

   request_pending_scheduler_16 #(.EDGE_DETECT(1)) dut (
      .Clock_In          (clk),
      .Reset_N_In        (rst_n),
      .Enable_In         (enable),
      .Request_In        (request),
      .Mask_In           (mask),
      .Clear_All_In      (clear_all),
      .Grant_Ready_In    (grant_ready),
      .Grant_Valid_Out   (grant_valid),
      .Grant_Index_Out   (grant_index),
      .Pending_Out       (pending),
      .Overflow_Out      (overflow),
      .Overflow_Clear_In (overflow_clear),
      .Dbg_State_Out     (dbg_state)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted grant must match the next expected index.
   always @(negedge clk) begin
      if (rst_n && grant_valid && grant_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_unexpected_grant: got index %0d, expected no grant", grant_index);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (grant_index !== e) $display("FAIL scoreboard_grant_index: got %0d, expected %0d", grant_index, e);
            else n_pass++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({grant_valid, grant_index, pending, overflow, dbg_state} !== {1'b0, 4'd0, 16'h0, 1'b0, IDLE})
         $display("FAIL reset_outputs: got v=%0b i=%0d p=%h o=%0b s=%0d, expected all zero", grant_valid, grant_index, pending, overflow, dbg_state);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      request = 16'h0020; exp_q.push_back(4'd5);
      tick(); request = '0;
      n_checks++;
      if (pending !== 16'h0020 || grant_valid !== 1'b0) $display("FAIL single_pending: got p=%h v=%0b, expected p=0020 v=0", pending, grant_valid);
      else n_pass++;
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_index !== 4'd5) $display("FAIL single_offer: got v=%0b i=%0d, expected v=1 i=5", grant_valid, grant_index);
      else n_pass++;
      grant_ready = 1'b1;
      tick(); grant_ready = 1'b0;
      n_checks++;
      if (pending !== 16'h0 || grant_valid !== 1'b0) $display("FAIL single_retire: got p=%h v=%0b, expected p=0000 v=0", pending, grant_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] order[3];
      order[0] = 4'd3; order[1] = 4'd9; order[2] = 4'd15;
      request = 16'h8208; grant_ready = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(order[i]);
      tick(); request = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (grant_valid !== 1'b1 || grant_index !== order[i]) $display("FAIL b2b_offer: got v=%0b i=%0d, expected v=1 i=%0d", grant_valid, grant_index, order[i]);
         else n_pass++;
         tick();
         n_checks++;
         if (grant_valid !== 1'b0) $display("FAIL b2b_bubble: got v=%0b, expected v=0", grant_valid);
         else n_pass++;
      end
      grant_ready = 1'b0;
      n_checks++;
      if (pending !== 16'h0) $display("FAIL b2b_drained: got p=%h, expected p=0000", pending);
      else n_pass++;
   endtask

   task automatic test_mask();
      mask = 16'h0004; request = 16'h0084; exp_q.push_back(4'd7);
      tick(); request = '0;
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_index !== 4'd7) $display("FAIL mask_skip: got v=%0b i=%0d, expected v=1 i=7", grant_valid, grant_index);
      else n_pass++;
      mask = 16'h0084;
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_index !== 4'd7) $display("FAIL mask_hold: got v=%0b i=%0d, expected v=1 i=7", grant_valid, grant_index);
      else n_pass++;
      mask = 16'h0004; grant_ready = 1'b1;
      tick(); grant_ready = 1'b0;
      tick();
      n_checks++;
      if (grant_valid !== 1'b0 || pending !== 16'h0004) $display("FAIL mask_blocked: got v=%0b p=%h, expected v=0 p=0004", grant_valid, pending);
      else n_pass++;
      mask = '0; exp_q.push_back(4'd2);
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_index !== 4'd2) $display("FAIL mask_release: got v=%0b i=%0d, expected v=1 i=2", grant_valid, grant_index);
      else n_pass++;
      grant_ready = 1'b1;
      tick(); grant_ready = 1'b0;
   endtask

   task automatic test_overflow();
      request = 16'h0010; exp_q.push_back(4'd4);
      tick(); request = '0;
      tick();
      grant_ready = 1'b1; request = 16'h0010; exp_q.push_back(4'd4);
      tick(); grant_ready = 1'b0; request = '0;
      n_checks++;
      if (pending !== 16'h0010 || overflow !== 1'b0 || grant_valid !== 1'b0) $display("FAIL rearm_on_accept: got p=%h o=%0b v=%0b, expected p=0010 o=0 v=0", pending, overflow, grant_valid);
      else n_pass++;
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_index !== 4'd4) $display("FAIL rearm_reoffer: got v=%0b i=%0d, expected v=1 i=4", grant_valid, grant_index);
      else n_pass++;
      grant_ready = 1'b1;
      tick(); grant_ready = 1'b0;
      mask = 16'h0040; request = 16'h0040;
      tick(); request = '0;
      tick(); request = 16'h0040;
      tick(); request = '0;
      n_checks++;
      if (overflow !== 1'b1 || pending !== 16'h0040) $display("FAIL overflow_set: got o=%0b p=%h, expected o=1 p=0040", overflow, pending);
      else n_pass++;
      overflow_clear = 1'b1;
      tick(); overflow_clear = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL overflow_clear: got o=%0b, expected o=0", overflow);
      else n_pass++;
      mask = '0; exp_q.push_back(4'd6);
      tick();
      grant_ready = 1'b1;
      tick(); grant_ready = 1'b0;
   endtask

   task automatic test_clear_all();
      request = 16'h0002;
      tick(); request = '0;
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_index !== 4'd1) $display("FAIL flush_offer: got v=%0b i=%0d, expected v=1 i=1", grant_valid, grant_index);
      else n_pass++;
      clear_all = 1'b1; request = 16'h0008;
      tick(); clear_all = 1'b0; request = '0;
      n_checks++;
      if (grant_valid !== 1'b0 || pending !== 16'h0) $display("FAIL flush_drop: got v=%0b p=%h, expected v=0 p=0000", grant_valid, pending);
      else n_pass++;
      tick();
      n_checks++;
      if (grant_valid !== 1'b0 || pending !== 16'h0) $display("FAIL flush_event_lost: got v=%0b p=%h, expected v=0 p=0000", grant_valid, pending);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         int k;
         k = $urandom_range(0, 15);
         request = 16'h0001 << k; exp_q.push_back(k[3:0]);
         tick(); request = '0; grant_ready = 1'b1;
         tick();
         tick(); grant_ready = 1'b0;
         n_checks++;
         if (pending !== 16'h0 || grant_valid !== 1'b0) $display("FAIL random_retire: got p=%h v=%0b, expected p=0000 v=0 (bit %0d)", pending, grant_valid, k);
         else n_pass++;
      end
   endtask

   task automatic test_enable_and_async_reset();
      enable = 1'b0; request = 16'h0001; overflow_clear = 1'b0;
      tick(); request = '0;
      tick(); tick();
      n_checks++;
      if (grant_valid !== 1'b0 || pending !== 16'h0001) $display("FAIL enable_hold: got v=%0b p=%h, expected v=0 p=0001", grant_valid, pending);
      else n_pass++;
      enable = 1'b1;
      tick();
      n_checks++;
      if (grant_valid !== 1'b1 || grant_index !== 4'd0) $display("FAIL enable_offer: got v=%0b i=%0d, expected v=1 i=0", grant_valid, grant_index);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({grant_valid, grant_index, pending, overflow} !== {1'b0, 4'd0, 16'h0, 1'b0}) $display("FAIL async_reset: got v=%0b i=%0d p=%h o=%0b, expected all zero", grant_valid, grant_index, pending, overflow);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_mask();
      test_overflow();
      test_clear_all();
      test_random();
      test_enable_and_async_reset();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d ungranted entries, expected 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
